ntt_result_serializer: RTL and testbench
========================================

# ntt_result_serializer

Streaming reader on the output side of the NTT/INTT processing unit. It captures one complete D×N-bit result vector when the unit signals completion, then emits the D coefficients one per cycle over a valid/ready handshake. Forward-transform results can optionally be reordered from bit-reversed to natural order. The block is the consumer counterpart to the parallel coefficient load path, decoupling the unit from downstream memory or host back-pressure.

## Interface
Parameters:
- N, 17, coefficient width in bits
- D, 16, coefficients per vector (power of two, ≥2)
- BITREV, 1, when 1, forward (inv=0) results are emitted in bit-reversed index order; inverse results are always emitted in natural order

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  single-cycle pulse: an_in is valid this cycle and is to be captured
- inv  in  1  transform direction of the vector on an_in, sampled with start
- an_in  in  D*N  result vector; coefficient k at bits [N*(k+1)-1 : N*k]
- in_ready  out  1  block can accept start this cycle
- coef_out  out  N  current coefficient
- coef_idx  out  $clog2(D)  natural-order index of coef_out
- coef_valid  out  1  coef_out/coef_idx/coef_last valid
- coef_ready  in  1  downstream accepts the current coefficient
- coef_last  out  1  current coefficient is the final one of the vector
- coef_inv  out  1  captured inv, constant for the whole vector
- overrun  out  1  sticky: start arrived while in_ready was 0

## Operation
- States: IDLE, STREAM.
- IDLE: in_ready=1, coef_valid=0. start → capture an_in and inv into the vector register, counter cnt=0, go to STREAM.
- STREAM: coef_valid=1. Emitted index = bitrev(cnt) when BITREV=1 and captured inv=0, else cnt. coef_out = captured coefficient at that index; coef_idx = that index. coef_last = (cnt == D-1).
- Handshake: transfer occurs when coef_valid && coef_ready; cnt increments by 1. Outputs stay stable while coef_valid && !coef_ready.
- Transfer with coef_last: if start is also high that cycle, capture the new vector, cnt wraps to 0, remain in STREAM (no bubble); otherwise return to IDLE.
- in_ready = IDLE || (STREAM && coef_last && coef_ready).
- start while in_ready=0: vector ignored, captured data unchanged, overrun set to 1; cleared only by reset.
- cnt is $clog2(D) bits; wraps from D-1 to 0 only on a last transfer.
- Reset (any time, including mid-vector): state IDLE, cnt=0, coef_valid=0, coef_last=0, coef_out=0, coef_idx=0, coef_inv=0, overrun=0, vector register cleared; partial vector discarded.

## Timing
- start sampled at edge t → coef_valid=1 with first coefficient after edge t (visible in cycle t+1).
- With coef_ready held high: D coefficients in D consecutive cycles; back-to-back vectors with zero idle cycles when start coincides with the last transfer.
- All outputs registered or decoded from registered state only; no combinational path from coef_ready to coef_out/coef_valid. in_ready is combinational from coef_ready (documented path).
- Vector capture latency 1 cycle; start→coef_last minimum D cycles.

## Structure
- Shared package: index width constant IDXW = $clog2(D), function bitrev(index, IDXW).
- One sub-module: ntt_out_index_gen — counter cnt, last flag, bit-reverse mapping selected by BITREV and captured inv; outputs emitted index and coef_last.
- Vector register and D:1 coefficient select live in the top module.

## Test plan
- Reset mid-stream: D=16, assert rst low after 5 transfers → all outputs 0 next cycle, in_ready=1; new start streams from index 0.
- Natural order: inv=1, an_in coefficient k = k+1, coef_ready=1 → coef_out 1,2,…,16, coef_idx 0…15, coef_last only on 16th, coef_inv=1.
- Bit-reversed: BITREV=1, inv=0, same vector → coef_idx 0,8,4,12,2,10,…,15, coef_out = idx+1; with BITREV=0 → natural order.
- Back-pressure: coef_ready toggled 1,0,0,1,… → coef_out/coef_idx stable during stalls, exactly 16 transfers, no duplicates or skips.
- Back-to-back: start coincident with last transfer of vector A (values k+1), vector B (values 100+k) → B index 0 appears next cycle, no idle cycle, overrun=0.
- Overrun: start at transfer 3 of a vector → overrun=1 sticky, current vector completes unchanged, second vector never emitted.

Source files
------------

// File: rtl/ntt_result_serializer_pkg.sv
// ntt_result_serializer_pkg: shared constants, FSM state type and index bit-reversal helper.
// Revision: 1.0
`default_nettype none

package ntt_result_serializer_pkg;

  localparam int DEF_N = 17;
  localparam int DEF_D = 16;
  localparam int IDXW  = $clog2(DEF_D);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Reverses the low 'width' bits of 'index'; higher bits are dropped.
  function automatic int unsigned bitrev(input int unsigned index, input int unsigned width);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width && index[i]) r[width-1-i] = 1'b1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_result_serializer_if.sv
// ntt_result_serializer_if: vector capture and coefficient stream signals of the serializer.
// Revision: 1.0
`default_nettype none

interface ntt_result_serializer_if #(
  parameter int N = 17,
  parameter int D = 16
);
  localparam int IW = $clog2(D);

  logic             start;
  logic             inv;
  logic [D*N-1:0]   an_in;
  logic             in_ready;
  logic [N-1:0]     coef_out;
  logic [IW-1:0]    coef_idx;
  logic             coef_valid;
  logic             coef_ready;
  logic             coef_last;
  logic             coef_inv;
  logic             overrun;

  modport slave (
    input  start, inv, an_in, coef_ready,
    output in_ready, coef_out, coef_idx, coef_valid, coef_last, coef_inv, overrun
  );

  modport master (
    output start, inv, an_in, coef_ready,
    input  in_ready, coef_out, coef_idx, coef_valid, coef_last, coef_inv, overrun
  );
endinterface

`default_nettype wire

// File: rtl/ntt_out_index_gen.sv
// ntt_out_index_gen: position counter, last flag and natural/bit-reversed emitted index.
// Revision: 1.0
`default_nettype none

module ntt_out_index_gen
  import ntt_result_serializer_pkg::*;
#(
  parameter int D      = 16,
  parameter int BITREV = 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 advance,
  input  wire logic                 inv,
  output logic [$clog2(D)-1:0]      idx,
  output logic                      cnt_last
);
  localparam int IW = $clog2(D);

  logic [IW-1:0] cnt_q;
  logic [IW-1:0] cnt_d;

  // Counter wraps D-1 -> 0 naturally, so a last transfer leaves it ready for the next vector.
  always_comb begin
    cnt_d = cnt_q;
    if (advance) cnt_d = cnt_q + IW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_last = (cnt_q == IW'(D - 1));

  if (BITREV != 0) begin : g_bitrev
    assign idx = inv ? cnt_q : IW'(bitrev(32'(cnt_q), IW));
  end else begin : g_natural
    assign idx = cnt_q;
  end

endmodule

`default_nettype wire

// File: rtl/ntt_result_serializer.sv
// ntt_result_serializer: captures a D*N-bit NTT result vector and streams it one coefficient per handshake.
// Revision: 1.0
`default_nettype none

module ntt_result_serializer
  import ntt_result_serializer_pkg::*;
#(
  parameter int N      = 17,
  parameter int D      = 16,
  parameter int BITREV = 1
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  ntt_result_serializer_if.slave     bus
);
  localparam int IW = $clog2(D);

  state_e          state_q, state_d;
  logic [D*N-1:0]  vec_q, vec_d;
  logic            inv_q, inv_d;
  logic            overrun_q, overrun_d;

  logic            w_stream;
  logic            w_xfer;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_cnt_last;
  logic [IW-1:0]   w_idx;
  logic [N-1:0]    coef_arr [D];

  assign w_stream   = (state_q == ST_STREAM);
  assign w_xfer     = w_stream && bus.coef_ready;
  // Only path from coef_ready to an output: lets a new vector land in the same cycle as the last transfer.
  assign w_in_ready = !w_stream || (w_cnt_last && bus.coef_ready);
  assign w_accept   = bus.start && w_in_ready;

  ntt_out_index_gen #(
    .D      (D),
    .BITREV (BITREV)
  ) u_index_gen (
    .clk      (clk),
    .rst      (rst),
    .advance  (w_xfer),
    .inv      (inv_q),
    .idx      (w_idx),
    .cnt_last (w_cnt_last)
  );

  for (genvar k = 0; k < D; k++) begin : g_split
    assign coef_arr[k] = vec_q[k*N +: N];
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    inv_d     = inv_q;
    overrun_d = overrun_q | (bus.start & ~w_in_ready);
    if (w_accept) begin
      vec_d = bus.an_in;
      inv_d = bus.inv;
    end
    case (state_q)
      ST_IDLE:   if (w_accept) state_d = ST_STREAM;
      ST_STREAM: if (w_xfer && w_cnt_last && !w_accept) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      inv_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      inv_q     <= inv_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.coef_valid = w_stream;
  assign bus.coef_last  = w_stream && w_cnt_last;
  assign bus.coef_idx   = w_idx;
  assign bus.coef_out   = coef_arr[w_idx];
  assign bus.coef_inv   = inv_q;
  assign bus.overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ntt_result_serializer.sv
// tb_ntt_result_serializer: random and directed stimulus checked against a queue/array reference model.
// Revision: 1.0
`default_nettype none

module tb_ntt_result_serializer;
  localparam int N  = 17;
  localparam int D  = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic           inv = 1'b0;
  logic           coef_ready = 1'b0;
  logic [D*N-1:0] an_in = '0;

  ntt_result_serializer_if #(.N(N), .D(D)) if0 ();
  ntt_result_serializer_if #(.N(N), .D(D)) if1 ();

  assign if0.start = start;  assign if1.start = start;
  assign if0.inv = inv;      assign if1.inv = inv;
  assign if0.an_in = an_in;  assign if1.an_in = an_in;
  assign if0.coef_ready = coef_ready;
  assign if1.coef_ready = coef_ready;

  ntt_result_serializer #(.N(N), .D(D), .BITREV(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  ntt_result_serializer #(.N(N), .D(D), .BITREV(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: the captured vector, its direction, and how many coefficients have gone out.
  logic [N-1:0] m_vec [D] = '{default: '0};
  bit m_active = 0;
  bit m_inv    = 0;
  bit m_ovr    = 0;
  int m_cnt    = 0;
  bit m_last, m_rdy;

  function automatic int rev(input int c);
    int r = 0;
    for (int i = 0; i < IW; i++) if (c[i]) r[IW-1-i] = 1'b1;
    return r;
  endfunction

  function automatic int exp_idx(input bit br, input int c);
    return (br && !m_inv) ? rev(c) : c;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < D; k++) m_vec[k] = '0;
      m_active = 0; m_inv = 0; m_ovr = 0; m_cnt = 0;
    end else begin
      m_last = m_active && (m_cnt == D - 1);
      m_rdy  = !m_active || (m_last && coef_ready);
      if (start && !m_rdy) m_ovr = 1;
      if (m_active && coef_ready) begin
        if (m_last) begin m_cnt = 0; m_active = 0; end
        else m_cnt++;
      end
      if (start && m_rdy) begin
        for (int k = 0; k < D; k++) m_vec[k] = an_in[k*N +: N];
        m_inv = inv; m_cnt = 0; m_active = 1;
      end
    end
  end

  typedef struct { int idx; int val; bit last; bit inv; } xfer_t;
  xfer_t log0[$];
  xfer_t log1[$];

  task automatic check_dut(input int id, input bit br, input logic v, input logic [IW-1:0] idx,
                           input logic [N-1:0] out, input logic last, input logic cinv,
                           input logic ovr, input logic ird);
    int e;
    xfer_t x;
    chk($sformatf("d%0d valid", id), 64'(v), 64'(m_active));
    if (m_active) begin
      e = exp_idx(br, m_cnt);
      chk($sformatf("d%0d idx", id), 64'(idx), 64'(e));
      chk($sformatf("d%0d out", id), 64'(out), 64'(m_vec[e]));
      chk($sformatf("d%0d last", id), 64'(last), 64'(m_cnt == D - 1));
    end else begin
      chk($sformatf("d%0d last idle", id), 64'(last), 64'(0));
    end
    chk($sformatf("d%0d inv", id), 64'(cinv), 64'(m_inv));
    chk($sformatf("d%0d overrun", id), 64'(ovr), 64'(m_ovr));
    chk($sformatf("d%0d in_ready", id), 64'(ird),
        64'(!m_active || (m_cnt == D - 1 && coef_ready)));
    if (v === 1'b1 && coef_ready) begin
      x.idx = int'(idx); x.val = int'(out); x.last = last; x.inv = cinv;
      if (id == 0) log0.push_back(x); else log1.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, 1'b1, if0.coef_valid, if0.coef_idx, if0.coef_out, if0.coef_last,
              if0.coef_inv, if0.overrun, if0.in_ready);
    check_dut(1, 1'b0, if1.coef_valid, if1.coef_idx, if1.coef_out, if1.coef_last,
              if1.coef_inv, if1.overrun, if1.in_ready);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input bit iv, input int base);
    inv = iv;
    for (int k = 0; k < D; k++) an_in[k*N +: N] = N'(base + k);
  endtask

  task automatic check_outputs_cleared(input string tag);
    chk({tag, " valid"}, 64'(if0.coef_valid), 64'(0));
    chk({tag, " out"}, 64'(if0.coef_out), 64'(0));
    chk({tag, " idx"}, 64'(if0.coef_idx), 64'(0));
    chk({tag, " last"}, 64'(if0.coef_last), 64'(0));
    chk({tag, " inv"}, 64'(if0.coef_inv), 64'(0));
    chk({tag, " overrun"}, 64'(if0.overrun), 64'(0));
    chk({tag, " in_ready"}, 64'(if0.in_ready), 64'(1));
  endtask

  int brtab [D] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  initial begin
    step(3);
    @(negedge clk); #1;
    check_outputs_cleared("reset");
    step(1);
    rst = 1'b1;
    step(2);

    // Natural order, inverse transform
    log0.delete(); log1.delete();
    load_vec(1, 1); start = 1; coef_ready = 1;
    step(1); start = 0;
    step(18);
    chk("nat count", 64'(log0.size()), 64'(16));
    for (int k = 0; k < log0.size(); k++) begin
      chk("nat out", 64'(log0[k].val), 64'(k + 1));
      chk("nat idx", 64'(log0[k].idx), 64'(k));
      chk("nat last", 64'(log0[k].last), 64'(k == 15));
      chk("nat inv", 64'(log0[k].inv), 64'(1));
    end

    // Forward transform: bit-reversed on dut0, natural on dut1
    log0.delete(); log1.delete();
    load_vec(0, 1); start = 1;
    step(1); start = 0;
    step(18);
    chk("brev count", 64'(log0.size()), 64'(16));
    chk("nobrev count", 64'(log1.size()), 64'(16));
    for (int k = 0; k < log0.size() && k < D; k++) begin
      chk("brev idx", 64'(log0[k].idx), 64'(brtab[k]));
      chk("brev out", 64'(log0[k].val), 64'(brtab[k] + 1));
    end
    for (int k = 0; k < log1.size() && k < D; k++)
      chk("nobrev idx", 64'(log1[k].idx), 64'(k));

    // Back-pressure 1,0,0 pattern
    log0.delete(); log1.delete();
    load_vec(1, 1); start = 1; coef_ready = 1;
    step(1); start = 0;
    for (int c = 0; c < 60; c++) begin
      coef_ready = (c % 3 == 0);
      step(1);
    end
    coef_ready = 1;
    step(2);
    chk("bp count", 64'(log0.size()), 64'(16));
    for (int k = 0; k < log0.size(); k++)
      chk("bp out", 64'(log0[k].val), 64'(k + 1));

    // Back-to-back vectors
    log0.delete(); log1.delete();
    load_vec(1, 1); start = 1;
    step(1); start = 0;
    step(15);
    load_vec(1, 100); start = 1;
    step(1); start = 0;
    step(18);
    chk("b2b count", 64'(log0.size()), 64'(32));
    if (log0.size() >= 17) begin
      chk("b2b A last val", 64'(log0[15].val), 64'(16));
      chk("b2b A last flag", 64'(log0[15].last), 64'(1));
      chk("b2b B first idx", 64'(log0[16].idx), 64'(0));
      chk("b2b B first val", 64'(log0[16].val), 64'(100));
    end
    chk("b2b overrun", 64'(if0.overrun), 64'(0));

    // Overrun
    log0.delete(); log1.delete();
    load_vec(1, 1); start = 1;
    step(1); start = 0;
    step(2);
    load_vec(1, 200); start = 1;
    step(1); start = 0;
    step(18);
    chk("ovr flag", 64'(if0.overrun), 64'(1));
    chk("ovr count", 64'(log0.size()), 64'(16));
    for (int k = 0; k < log0.size(); k++)
      chk("ovr out", 64'(log0[k].val), 64'(k + 1));
    step(3);
    chk("ovr sticky", 64'(if0.overrun), 64'(1));

    // Reset mid-stream after 5 transfers
    log0.delete(); log1.delete();
    load_vec(1, 1); start = 1;
    step(1); start = 0;
    step(5);
    rst = 1'b0;
    @(negedge clk); #1;
    check_outputs_cleared("midrst");
    chk("midrst transfers", 64'(log0.size()), 64'(5));
    step(1);
    rst = 1'b1;
    step(1);
    log0.delete(); log1.delete();
    load_vec(0, 1); start = 1;
    step(1); start = 0;
    step(18);
    chk("post-rst count", 64'(log0.size()), 64'(16));
    if (log0.size() > 1) begin
      chk("post-rst first idx", 64'(log0[0].idx), 64'(0));
      chk("post-rst second idx", 64'(log0[1].idx), 64'(8));
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      coef_ready = ($urandom % 4) != 0;
      start = ($urandom % 6) == 0;
      if (start) begin
        inv = 1'($urandom % 2);
        for (int k = 0; k < D; k++) an_in[k*N +: N] = N'($urandom);
      end
      step(1);
    end
    start = 0; coef_ready = 1;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
